// File: rtl/dz_scan_ctrl_if.sv
// Bus bundle between pattern logic and the 8x8 LED row-scan controller.
// DZ_SCAN_BRIGHT_EN adds the bright[2:0] dimming input.
interface dz_scan_ctrl_if;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_g;
  logic [7:0] wr_r;
  logic       wr_ready;
  logic       swap_req;
  logic       swap_ack;
  logic [7:0] row;
  logic [7:0] colg;
  logic [7:0] colr;
  logic       frame_tick;
`ifdef DZ_SCAN_BRIGHT_EN
  logic [2:0] bright;
`endif

  modport master (
`ifdef DZ_SCAN_BRIGHT_EN
    output bright,
`endif
    output wr_en, wr_addr, wr_g, wr_r,
    output swap_req,
    input  wr_ready, swap_ack,
    input  row, colg, colr, frame_tick
  );

  modport slave (
`ifdef DZ_SCAN_BRIGHT_EN
    input  bright,
`endif
    input  wr_en, wr_addr, wr_g, wr_r,
    input  swap_req,
    output wr_ready, swap_ack,
    output row, colg, colr, frame_tick
  );
endinterface

// File: rtl/dz_scan_ctrl.sv
// Double-buffered 8x8 bicolour LED row scanner with frame-aligned swap.
// DZ_SCAN_BRIGHT_EN enables per-row duty dimming via bus.bright.
module dz_scan_ctrl #(
  parameter int ROW_CYCLES   = 250,
  parameter int BLANK_CYCLES = 2
) (
  input logic           clk,
  input logic           rst,
  dz_scan_ctrl_if.slave bus
);
  localparam int CW = $clog2(ROW_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    ridx_q, ridx_d;
  logic          pend_q, pend_d;
  logic          sel_q, sel_d;
  logic          bk;
  logic [7:0]    g_q [2][8];
  logic [7:0]    r_q [2][8];
  logic [7:0]    lg_q, lg_d, lr_q, lr_d;
  logic [7:0]    row_q, row_d;
  logic [7:0]    colg_q, colg_d;
  logic [7:0]    colr_q, colr_d;
  logic          ack_q, ack_d;
  logic          tick_q, tick_d;
  logic          last_cnt, blank, first_show;
  logic          fire, duty;

`ifdef DZ_SCAN_BRIGHT_EN
  logic [2:0] bright_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      bright_q <= 3'd7;
    end else if (cnt_q == '0) begin
      bright_q <= bus.bright;
    end
  end

  assign duty = (int'(cnt_q) - BLANK_CYCLES) <
    (((int'(bright_q) + 1) *
      (ROW_CYCLES - BLANK_CYCLES)) / 8);
`else
  assign duty = 1'b1;
`endif

  assign bk         = ~sel_q;
  assign last_cnt   = cnt_q == CW'(ROW_CYCLES - 1);
  assign blank      = cnt_q < CW'(BLANK_CYCLES);
  assign first_show = cnt_q == CW'(BLANK_CYCLES);
  // frame_tick_q marks the visible final cycle of the frame
  assign fire       = tick_q & (pend_q | bus.swap_req);

  always_comb begin
    cnt_d  = last_cnt ? '0 : cnt_q + CW'(1);
    ridx_d = last_cnt ? ridx_q + 3'd1 : ridx_q;
    sel_d  = sel_q ^ fire;
    pend_d = fire ? 1'b0 : (pend_q | bus.swap_req);
    ack_d  = fire;
    tick_d = (ridx_q == 3'd7) && last_cnt;
    lg_d   = first_show ? g_q[sel_q][ridx_q] : lg_q;
    lr_d   = first_show ? r_q[sel_q][ridx_q] : lr_q;
    row_d  = blank ? 8'hFF : ~(8'h01 << ridx_q);
    colg_d = (blank || !duty) ? 8'h00 : lg_d;
    colr_d = (blank || !duty) ? 8'h00 : lr_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      ridx_q <= '0;
      pend_q <= 1'b0;
      sel_q  <= 1'b0;
      lg_q   <= '0;
      lr_q   <= '0;
      row_q  <= 8'hFF;
      colg_q <= '0;
      colr_q <= '0;
      ack_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      ridx_q <= ridx_d;
      pend_q <= pend_d;
      sel_q  <= sel_d;
      lg_q   <= lg_d;
      lr_q   <= lr_d;
      row_q  <= row_d;
      colg_q <= colg_d;
      colr_q <= colr_d;
      ack_q  <= ack_d;
      tick_q <= tick_d;
    end
  end

  // back-buffer write uses the pre-swap select, so a boundary write lands in the new front
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < 8; i++) begin
          g_q[b][i] <= '0;
          r_q[b][i] <= '0;
        end
      end
    end else if (bus.wr_en && !pend_q) begin
      g_q[bk][bus.wr_addr] <= bus.wr_g;
      r_q[bk][bus.wr_addr] <= bus.wr_r;
    end
  end

  assign bus.wr_ready   = ~pend_q;
  assign bus.swap_ack   = ack_q;
  assign bus.row        = row_q;
  assign bus.colg       = colg_q;
  assign bus.colr       = colr_q;
  assign bus.frame_tick = tick_q;
endmodule

// File: tb/tb_dz_scan_ctrl.sv
// Randomized self-checking bench for dz_scan_ctrl against a frame-level model.
// Honours DZ_SCAN_BRIGHT_EN (bright held at 3).
module tb_dz_scan_ctrl;
  localparam int RC = 8;
  localparam int BC = 2;
  localparam int FR = 8 * RC;

  logic clk = 1'b0;
  logic rst = 1'b1;
  dz_scan_ctrl_if bus ();

  dz_scan_ctrl #(
    .ROW_CYCLES  (RC),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;
  int          n;
  logic [7:0]  mg [2][8];
  logic [7:0]  mr [2][8];
  int          mf;
  bit          mp;
  bit          eack;
  int          bright_m = 7;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h",
               tag, n, got, exp);
    end
  endtask

  task automatic idle_in();
    bus.wr_en    = 1'b0;
    bus.wr_addr  = 3'd0;
    bus.wr_g     = 8'h00;
    bus.wr_r     = 8'h00;
    bus.swap_req = 1'b0;
  endtask

  task automatic check_outputs();
    int p, ri, c;
    bit on;
    logic [7:0] one, er, eg, ed;
    one = 8'h01;
    p  = n % FR;
    ri = p / RC;
    c  = p % RC;
    er = 8'hFF;
    eg = 8'h00;
    ed = 8'h00;
    if (c >= BC) begin
      er = ~(one << ri);
      on = (c - BC) < (((bright_m + 1) * (RC - BC)) / 8);
      if (on) begin
        eg = mg[mf][ri];
        ed = mr[mf][ri];
      end
    end
    chk("row", bus.row, er);
    chk("colg", bus.colg, eg);
    chk("colr", bus.colr, ed);
    chk("frame_tick", bus.frame_tick, p == FR - 1);
    chk("swap_ack", bus.swap_ack, eack);
    chk("wr_ready", bus.wr_ready, !mp);
  endtask

  // advance one clock: model consumes this cycle's inputs
  task automatic step();
    bit fire;
    fire = (n % FR == FR - 1) && (mp || bus.swap_req);
    if (bus.wr_en && !mp) begin
      mg[1 - mf][bus.wr_addr] = bus.wr_g;
      mr[1 - mf][bus.wr_addr] = bus.wr_r;
    end
    if (fire) begin
      mf = 1 - mf;
      mp = 1'b0;
    end else if (bus.swap_req) begin
      mp = 1'b1;
    end
    eack = fire;
    @(posedge clk);
    #1;
    n++;
    check_outputs();
  endtask

  task automatic idle_step();
    idle_in();
    step();
  endtask

  task automatic run_to(int pos);
    idle_in();
    for (int k = 0; k < FR && (n % FR) != pos; k++)
      step();
  endtask

  task automatic do_reset(int cyc);
    idle_in();
    rst = 1'b1;
    for (int k = 0; k < cyc; k++) begin
      @(posedge clk);
      #1;
      chk("rst_row", bus.row, 8'hFF);
      chk("rst_colg", bus.colg, 8'h00);
      chk("rst_colr", bus.colr, 8'h00);
      chk("rst_ready", bus.wr_ready, 1'b1);
      chk("rst_ack", bus.swap_ack, 1'b0);
      chk("rst_tick", bus.frame_tick, 1'b0);
    end
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 8; i++) begin
        mg[b][i] = 8'h00;
        mr[b][i] = 8'h00;
      end
    mf   = 0;
    mp   = 1'b0;
    eack = 1'b0;
    n    = -1;
    rst  = 1'b0;
  endtask

  initial begin
`ifdef DZ_SCAN_BRIGHT_EN
    bus.bright = 3'd3;
    bright_m   = 3;
`endif
    do_reset(3);
    for (int k = 0; k < FR + 4; k++)
      idle_step();

    run_to(20);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 3'd3;
    bus.wr_g    = 8'hA5;
    bus.wr_r    = 8'h3C;
    step();
    idle_in();
    bus.swap_req = 1'b1;
    step();
    chk("ready_drop", bus.wr_ready, 1'b0);
    run_to(FR - 1);
    idle_step();
    chk("ack_frame", bus.swap_ack, 1'b1);
    run_to(3 * RC + BC);
    chk("r3_row", bus.row, 8'hF7);
    chk("r3_colg", bus.colg, 8'hA5);
    chk("r3_colr", bus.colr, 8'h3C);

    bus.swap_req = 1'b1;
    step();
    bus.swap_req = 1'b0;
    bus.wr_en    = 1'b1;
    bus.wr_addr  = 3'd0;
    bus.wr_g     = 8'hFF;
    bus.wr_r     = 8'hFF;
    step();
    run_to(FR - 1);
    bus.swap_req = 1'b1;
    step();
    run_to(BC);
    chk("drop_r0", bus.colg, 8'h00);

    run_to(FR - 1);
    bus.swap_req = 1'b1;
    bus.wr_en    = 1'b1;
    bus.wr_addr  = 3'd7;
    bus.wr_g     = 8'h81;
    bus.wr_r     = 8'h18;
    step();
    chk("bnd_ack", bus.swap_ack, 1'b1);
    run_to(7 * RC + BC);
    chk("bnd_r7", bus.colg, 8'h81);

    for (int k = 0; k < 1500; k++) begin
      bus.wr_en    = ($urandom % 3) == 0;
      bus.wr_addr  = 3'($urandom);
      bus.wr_g     = 8'($urandom);
      bus.wr_r     = 8'($urandom);
      bus.swap_req = ($urandom % 40) == 0;
      step();
    end

    run_to(5 * RC + 3);
    bus.swap_req = 1'b1;
    step();
    chk("pend_r5", bus.wr_ready, 1'b0);
    do_reset(2);
    for (int k = 0; k < 2 * FR; k++)
      idle_step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dz_scan_ctrl.md
# dz_scan_ctrl

Row-scan controller for the 8x8 bicolour (green/red) LED dot matrix. It owns a double-buffered frame store and time-multiplexes the front buffer onto the row and column drivers one row at a time. Writers load the back buffer through a write port, then request a swap, which takes effect only at a frame boundary. It sits between the pattern/counter logic and the matrix pins, replacing direct row/column driving.

## Interface
- ROW_CYCLES, 250: clocks per row dwell, including blanking; must be > BLANK_CYCLES.
- BLANK_CYCLES, 2: clocks at the start of each row with all drivers off (anti-ghosting); must be ≥ 1.
- clk  in  1  system clock.
- rst  in  1  reset, synchronous and active-high.
- wr_en  in  1  write strobe for the back buffer.
- wr_addr  in  3  back-buffer row index.
- wr_g  in  8  green column bits for that row; bit i = column i.
- wr_r  in  8  red column bits for that row.
- wr_ready  out  1  high when writes are accepted.
- swap_req  in  1  single-cycle pulse requesting a buffer swap.
- swap_ack  out  1  one-cycle pulse when a swap has taken effect.
- row  out  8  row select, active-low, one-hot-zero.
- colg  out  8  green columns, active-high.
- colr  out  8  red columns, active-high.
- frame_tick  out  1  one-cycle pulse in the last cycle of row 7.

## Operation
- State: row index `ridx` (0..7), dwell counter `cnt` (0..ROW_CYCLES-1), phase BLANK (cnt < BLANK_CYCLES) / SHOW, swap-pending flag `pend`, front-select bit.
- Reset values:
  - All outputs: row=8'hFF, colg=8'h00, colr=8'h00, wr_ready=1, swap_ack=0, frame_tick=0.
  - Internal state: ridx=0, cnt=0, pend=0.
  - Both buffers cleared to all zeros.
- Counter behaviour:
  - cnt increments every cycle.
  - At cnt = ROW_CYCLES-1, cnt returns to 0 and ridx increments.
  - ridx wraps from 7 to 0.
- Phase outputs:
  - BLANK: row=8'hFF, colg=colr=0.
  - SHOW: row = ~(1<<ridx); colg and colr come from front[ridx].
- Writes:
  - wr_en with wr_ready high writes {wr_g, wr_r} into back[wr_addr].
  - wr_en with wr_ready low is dropped silently.
- Swap:
  - swap_req sets pend. A swap_req while pend is already set merges into it.
  - wr_ready = ~pend.
- Frame boundary (cycle with ridx=7 and cnt=ROW_CYCLES-1):
  - The swap fires if pend is set, or if swap_req is high in that cycle.
  - On firing, the front-select toggles at that edge and pend clears.
- Simultaneous events:
  - A write accepted in the same cycle as swap_req (wr_ready still high) is stored. If that cycle is also the boundary, the written data appears in the new front.
  - The old front becomes the back; its contents are kept, not cleared.
- Reset mid-frame returns to reset values; pending swaps and both buffer contents are discarded.

## Timing
- All outputs are registered and change only on the clk rising edge.
- After rst deasserts:
  - Cycles 0..BLANK_CYCLES-1 are blank.
  - First SHOW output (row=8'hFE) appears BLANK_CYCLES cycles after the first post-reset edge.
- Frame period is 8·ROW_CYCLES cycles.
- frame_tick is high during the final cycle of every frame.
- swap_ack is high during the first cycle of the new frame (ridx=0, cnt=0).
- wr_ready goes low the cycle after swap_req. It returns high in the same cycle swap_ack is high.
- Swap latency, from swap_req to swap_ack:
  - 1 to 8·ROW_CYCLES cycles.
  - Exactly 1 cycle if swap_req arrives in the frame's final cycle.
- Front-buffer data for a row is sampled at the BLANK-to-SHOW transition and held for the rest of that row's dwell.

## Configuration
- DZ_SCAN_BRIGHT_EN defined:
  - Adds input bright[2:0].
  - In SHOW, colg/colr are driven only while (cnt - BLANK_CYCLES) < ((bright+1)·(ROW_CYCLES-BLANK_CYCLES))/8, and forced to 0 otherwise. Row select is unaffected.
  - bright is sampled at each row start.
  - bright=7 gives full duty.
- Not defined: no bright port; full duty in SHOW.

## Test plan
Bench uses ROW_CYCLES=8, BLANK_CYCLES=2.
- Reset for 3 cycles, then release:
  - Outputs are 8'hFF/00/00 for 2 cycles, then row=8'hFE with colg=colr=0.
  - frame_tick first high 64 cycles after release.
- Swap flow:
  - Write back[3]={8'hA5,8'h3C}, then swap_req mid-frame.
  - wr_ready drops the next cycle.
  - swap_ack occurs at the next frame start.
  - In row 3 SHOW: row=8'hF7, colg=8'hA5, colr=8'h3C.
- Write dropped while pending: wr_en to back[0]=8'hFF while wr_ready=0. After a second swap, row 0 shows its prior content.
- Same-cycle boundary: swap_req plus write back[7]=8'h81 in the final frame cycle.
  - swap_ack is high the next cycle.
  - Row 7 of the new frame shows colg=8'h81.
- Mid-frame reset:
  - Assert rst during row 5 with pend set.
  - Required: row=8'hFF, pend cleared, no swap_ack, buffers zero.
- With DZ_SCAN_BRIGHT_EN and bright=3: each row shows column data for exactly 3 of its 6 SHOW cycles.
